tdm_demux2: RTL and testbench
=============================

TDM_DEMUX2 -- requirements
Module: tdm_demux2

Interface
REQ-001 SHALL have parameter WIDTH, default 1, data width per channel.
REQ-002 SHALL have parameter CNT_W, default 8, width of frame and error counters.
REQ-003 SHALL have port clk  input  1  sole clock; all state updates on posedge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous and active-high.
REQ-005 SHALL have port in_valid  input  1  in_data/in_sel qualify this cycle.
REQ-006 SHALL have port in_sel  input  1  channel tag: 0 = channel A, 1 = channel B.
REQ-007 SHALL have port in_data  input  WIDTH  time-multiplexed sample.
REQ-008 SHALL have port out_valid  output  1  one-cycle pulse: out_a/out_b hold a new complete pair.
REQ-009 SHALL have port out_a  output  WIDTH  demultiplexed channel A of last pair.
REQ-010 SHALL have port out_b  output  WIDTH  demultiplexed channel B of last pair.
REQ-011 SHALL have port frame_cnt  output  CNT_W  count of completed pairs.
REQ-012 SHALL have port seq_err  output  1  one-cycle pulse on tag-order violation.

Function
REQ-013 SHALL implement a two-state FSM: WAIT_A (expect sel=0), WAIT_B (expect sel=1).
REQ-014 WAIT_A, in_valid & in_sel=0: SHALL capture in_data into a holding register, go to WAIT_B.
REQ-015 WAIT_A, in_valid & in_sel=1: SHALL discard the sample, pulse seq_err next cycle, stay in WAIT_A.
REQ-016 WAIT_B, in_valid & in_sel=1: SHALL load out_a from the holding register and out_b from in_data, pulse out_valid next cycle, increment frame_cnt, go to WAIT_A.
REQ-017 WAIT_B, in_valid & in_sel=0: SHALL overwrite the holding register with in_data (frame restart), pulse seq_err next cycle, stay in WAIT_B.
REQ-018 in_valid=0: SHALL hold state, holding register, outputs; out_valid and seq_err low.
REQ-019 Latency: in_data of accepted B sample SHALL appear on out_b with out_valid exactly 1 cycle after the accepting edge.
REQ-020 out_a/out_b SHALL hold their values between pairs; only REQ-016 updates them.
REQ-021 frame_cnt SHALL wrap from 2^CNT_W-1 to 0 without error indication.
REQ-022 Back-to-back A,B,A,B on consecutive cycles SHALL yield one pair every 2 cycles, no bubbles required.
REQ-023 out_valid and seq_err SHALL never assert in the same cycle.

Reset
REQ-024 rst asserted SHALL asynchronously force: state WAIT_A, holding register 0, out_a 0, out_b 0, out_valid 0, seq_err 0, frame_cnt 0, err_cnt 0.
REQ-025 rst mid-frame (WAIT_B) SHALL discard the held A sample; first post-reset sel=1 sample SHALL raise seq_err.
REQ-026 Inputs SHALL be ignored on any edge where rst is high.

Configuration
REQ-027 Macro TDM_DEMUX2_ERRCNT_EN defined: SHALL add port err_cnt  output  CNT_W, incremented on every seq_err event, saturating at 2^CNT_W-1.
REQ-028 Macro undefined: err_cnt port and its logic SHALL be absent; all other behaviour identical.

Structure
REQ-029 Package tdm_pkg SHALL hold the FSM state enum (WAIT_A, WAIT_B) and channel-tag constants CH_A=1'b0, CH_B=1'b1.
REQ-030 Saturating counter SHALL be sub-module tdm_sat_cnt (parameter CNT_W, inputs clk, rst, inc; output count), instantiated only under TDM_DEMUX2_ERRCNT_EN.

Verification
REQ-031 Reset then A=1 (sel 0), B=0 (sel 1) on consecutive cycles -> out_valid pulse, out_a=1, out_b=0, frame_cnt=1.
REQ-032 WIDTH=8: stream A=0x5A,B=0xA5,A=0x11,B=0x22 back-to-back -> pairs (0x5A,0xA5) then (0x11,0x22), frame_cnt=2, no seq_err.
REQ-033 From WAIT_A send sel=1 data 0x33 -> seq_err pulse, no out_valid, outputs unchanged; err_cnt=1 when macro defined.
REQ-034 A=0x10, A=0x20, B=0x30 -> one seq_err, then pair (0x20,0x30).
REQ-035 A=0x44, assert rst one cycle, then B=0x55 -> all outputs 0 after reset, seq_err on B, no pair.
REQ-036 CNT_W=2: five complete pairs -> frame_cnt sequence 1,2,3,0,1; with macro, five seq_err events -> err_cnt 1,2,3,3,3.

Source files
------------

// File: rtl/tdm_pkg.sv
// tdm_pkg -- shared definitions for the two-channel TDM demultiplexer.
//   state_t : frame FSM states (WAIT_A expects a channel-A tag, WAIT_B a channel-B tag)
//   CH_A/CH_B : values carried on in_sel for each channel
package tdm_pkg;

  typedef enum logic {
    WAIT_A = 1'b0,
    WAIT_B = 1'b1
  } state_t;

  localparam logic CH_A = 1'b0;
  localparam logic CH_B = 1'b1;

endpackage

// File: rtl/tdm_sat_cnt.sv
// tdm_sat_cnt -- up-counter that sticks at all-ones instead of wrapping.
//   clk   : clock, posedge
//   rst   : asynchronous active-high reset, clears count
//   inc   : count one event this cycle
//   count : current event count, saturates at 2^CNT_W-1
module tdm_sat_cnt #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  output logic [CNT_W-1:0] count
);

  logic sat;
  assign sat = &count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)             count <= '0;
    else if (inc && !sat) count <= count + CNT_W'(1);
  end

endmodule

// File: rtl/tdm_demux2.sv
// tdm_demux2 -- splits an A,B,A,B,... tagged sample stream into parallel pairs.
//   clk       : clock, posedge
//   rst       : asynchronous active-high reset
//   in_valid  : in_sel/in_data qualify this cycle
//   in_sel    : channel tag, CH_A (0) or CH_B (1)
//   in_data   : time-multiplexed sample, WIDTH bits
//   out_valid : one-cycle pulse, out_a/out_b hold a fresh pair
//   out_a     : channel A of the last complete pair (held between pairs)
//   out_b     : channel B of the last complete pair (held between pairs)
//   frame_cnt : completed pairs, wraps modulo 2^CNT_W
//   seq_err   : one-cycle pulse after a sample whose tag is out of order
//   err_cnt   : (only with TDM_DEMUX2_ERRCNT_EN) saturating count of seq_err events
// Optional feature macro: TDM_DEMUX2_ERRCNT_EN adds err_cnt and its counter.
module tdm_demux2
  import tdm_pkg::*;
#(
  parameter int WIDTH = 1,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic             in_sel,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_a,
  output logic [WIDTH-1:0] out_b,
  output logic [CNT_W-1:0] frame_cnt,
  output logic             seq_err
`ifdef TDM_DEMUX2_ERRCNT_EN
  ,
  output logic [CNT_W-1:0] err_cnt
`endif
);

  state_t           state;
  logic [WIDTH-1:0] hold;

  // Decode of the four qualified (state, tag) cases.
  logic take_a, take_b, bad_b, restart, err_ev;
  assign take_a  = in_valid && (state == WAIT_A) && (in_sel == CH_A);
  assign bad_b   = in_valid && (state == WAIT_A) && (in_sel == CH_B);
  assign take_b  = in_valid && (state == WAIT_B) && (in_sel == CH_B);
  // A second A before any B restarts the frame with the newer A sample.
  assign restart = in_valid && (state == WAIT_B) && (in_sel == CH_A);
  assign err_ev  = bad_b || restart;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= WAIT_A;
      hold      <= '0;
      out_a     <= '0;
      out_b     <= '0;
      out_valid <= 1'b0;
      seq_err   <= 1'b0;
      frame_cnt <= '0;
    end else begin
      // Pulses are single-cycle; out_valid and seq_err come from mutually
      // exclusive decode terms so they can never coincide.
      out_valid <= take_b;
      seq_err   <= err_ev;
      unique case (state)
        WAIT_A: begin
          if (take_a) begin
            hold  <= in_data;
            state <= WAIT_B;
          end
        end
        WAIT_B: begin
          if (take_b) begin
            out_a     <= hold;
            out_b     <= in_data;
            frame_cnt <= frame_cnt + CNT_W'(1);
            state     <= WAIT_A;
          end else if (restart) begin
            hold <= in_data;
          end
        end
        default: state <= WAIT_A;
      endcase
    end
  end

`ifdef TDM_DEMUX2_ERRCNT_EN
  // Counts on the same edge that raises seq_err, so err_cnt is already
  // updated in the cycle the pulse is visible.
  tdm_sat_cnt #(.CNT_W(CNT_W)) u_err_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (err_ev),
    .count (err_cnt)
  );
`endif

endmodule

// File: tb/tb_tdm_demux2.sv
// tb_tdm_demux2 -- randomized and directed bench for tdm_demux2 (WIDTH=8, CNT_W=2).
module tb_tdm_demux2;

  localparam int W  = 8;
  localparam int CW = 2;
  localparam int CMAX = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          in_valid = 1'b0;
  logic          in_sel = 1'b0;
  logic [W-1:0]  in_data = '0;
  logic          out_valid;
  logic [W-1:0]  out_a, out_b;
  logic [CW-1:0] frame_cnt;
  logic          seq_err;
`ifdef TDM_DEMUX2_ERRCNT_EN
  logic [CW-1:0] err_cnt;
`endif

  int checks = 0;
  int errors = 0;

  // Reference model: "pending" means an A sample is waiting for its B partner.
  bit       m_pend;
  bit [7:0] m_hold, m_a, m_b;
  bit       m_vld, m_err;
  int       m_fcnt, m_ecnt;

  tdm_demux2 #(.WIDTH(W), .CNT_W(CW)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_sel    (in_sel),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_a     (out_a),
    .out_b     (out_b),
    .frame_cnt (frame_cnt),
    .seq_err   (seq_err)
`ifdef TDM_DEMUX2_ERRCNT_EN
    ,
    .err_cnt   (err_cnt)
`endif
  );

  always #5 clk = ~clk;

  task automatic model_clear();
    m_pend = 0; m_hold = 0; m_a = 0; m_b = 0;
    m_vld = 0; m_err = 0; m_fcnt = 0; m_ecnt = 0;
  endtask

  // Apply one sample across one rising edge; returns at the following negedge.
  task automatic tick(input bit v, input bit s, input bit [7:0] d);
    in_valid = v; in_sel = s; in_data = d;
    @(posedge clk);
    m_vld = 0; m_err = 0;
    if (v) begin
      if (!m_pend && !s) begin m_hold = d; m_pend = 1; end
      else if (!m_pend && s) m_err = 1;
      else if (m_pend && s) begin
        m_a = m_hold; m_b = d; m_vld = 1; m_pend = 0;
        m_fcnt = (m_fcnt + 1) % (CMAX + 1);
      end else begin m_hold = d; m_err = 1; end
    end
    if (m_err && m_ecnt < CMAX) m_ecnt++;
    @(negedge clk);
    in_valid = 0;
  endtask

  task automatic do_reset();
    rst = 1; in_valid = 1; in_sel = 1; in_data = 8'hFF;
    @(posedge clk);
    @(negedge clk);
    rst = 0; in_valid = 0;
    model_clear();
  endtask

  task automatic test_reset();
    do_reset();
    tick(1, 0, 8'hAB); tick(1, 1, 8'hCD);
    @(posedge clk); #2;
    rst = 1; in_valid = 1; in_sel = 0; in_data = 8'h77;
    #1;
    checks++;
    if ({out_valid, seq_err, out_a, out_b, frame_cnt} !== '0) begin
      errors++;
      $display("FAIL reset_async got v=%b e=%b a=%h b=%h f=%0d exp all 0", out_valid, seq_err, out_a, out_b, frame_cnt);
    end
`ifdef TDM_DEMUX2_ERRCNT_EN
    checks++;
    if (err_cnt !== '0) begin errors++; $display("FAIL reset_errcnt got %0d exp 0", err_cnt); end
`endif
    @(posedge clk); @(negedge clk);
    checks++;
    if ({out_valid, seq_err, out_a, out_b, frame_cnt} !== '0) begin
      errors++;
      $display("FAIL reset_ignores_inputs got v=%b a=%h f=%0d exp 0", out_valid, out_a, frame_cnt);
    end
    rst = 0; in_valid = 0; model_clear();
  endtask

  task automatic test_basic_pair();
    do_reset();
    tick(1, 0, 8'h01);
    checks++;
    if (out_valid !== 0 || seq_err !== 0) begin errors++; $display("FAIL basic_after_a got v=%b e=%b exp 0 0", out_valid, seq_err); end
    tick(1, 1, 8'h00);
    checks++;
    if (out_valid !== 1 || out_a !== 8'h01 || out_b !== 8'h00 || frame_cnt !== 2'd1) begin
      errors++; $display("FAIL basic_pair got v=%b a=%h b=%h f=%0d exp 1 01 00 1", out_valid, out_a, out_b, frame_cnt);
    end
    tick(0, 0, 8'h00);
    checks++;
    if (out_valid !== 0 || out_a !== 8'h01 || out_b !== 8'h00) begin
      errors++; $display("FAIL basic_hold got v=%b a=%h b=%h exp 0 01 00", out_valid, out_a, out_b);
    end
  endtask

  task automatic test_back_to_back();
    bit [7:0] st[4] = '{8'h5A, 8'hA5, 8'h11, 8'h22};
    do_reset();
    for (int i = 0; i < 4; i++) begin
      tick(1, i[0], st[i]);
      checks++;
      if (seq_err !== 0 || out_valid !== i[0]) begin
        errors++; $display("FAIL b2b_pulse[%0d] got v=%b e=%b exp %b 0", i, out_valid, seq_err, i[0]);
      end
      if (i[0]) begin
        checks++;
        if (out_a !== st[i-1] || out_b !== st[i] || frame_cnt !== CW'((i + 1) / 2)) begin
          errors++; $display("FAIL b2b_pair[%0d] got a=%h b=%h f=%0d exp %h %h %0d", i, out_a, out_b, frame_cnt, st[i-1], st[i], (i + 1) / 2);
        end
      end
    end
  endtask

  task automatic test_bad_b();
    do_reset();
    tick(1, 0, 8'h61); tick(1, 1, 8'h62);
    tick(1, 1, 8'h33);
    checks++;
    if (seq_err !== 1 || out_valid !== 0 || out_a !== 8'h61 || out_b !== 8'h62 || frame_cnt !== 2'd1) begin
      errors++; $display("FAIL bad_b got e=%b v=%b a=%h b=%h f=%0d exp 1 0 61 62 1", seq_err, out_valid, out_a, out_b, frame_cnt);
    end
`ifdef TDM_DEMUX2_ERRCNT_EN
    checks++;
    if (err_cnt !== 2'd1) begin errors++; $display("FAIL bad_b_errcnt got %0d exp 1", err_cnt); end
`endif
    tick(0, 0, 8'h00);
    checks++;
    if (seq_err !== 0) begin errors++; $display("FAIL bad_b_pulse_len got %b exp 0", seq_err); end
  endtask

  task automatic test_restart();
    do_reset();
    tick(1, 0, 8'h10);
    tick(1, 0, 8'h20);
    checks++;
    if (seq_err !== 1 || out_valid !== 0) begin errors++; $display("FAIL restart_err got e=%b v=%b exp 1 0", seq_err, out_valid); end
    tick(1, 1, 8'h30);
    checks++;
    if (seq_err !== 0 || out_valid !== 1 || out_a !== 8'h20 || out_b !== 8'h30) begin
      errors++; $display("FAIL restart_pair got e=%b v=%b a=%h b=%h exp 0 1 20 30", seq_err, out_valid, out_a, out_b);
    end
  endtask

  task automatic test_reset_midframe();
    do_reset();
    tick(1, 0, 8'h44);
    do_reset();
    checks++;
    if ({out_valid, seq_err, out_a, out_b, frame_cnt} !== '0) begin
      errors++; $display("FAIL midframe_reset got a=%h b=%h f=%0d exp 0", out_a, out_b, frame_cnt);
    end
    tick(1, 1, 8'h55);
    checks++;
    if (seq_err !== 1 || out_valid !== 0 || out_b !== 8'h00 || frame_cnt !== 2'd0) begin
      errors++; $display("FAIL midframe_b got e=%b v=%b b=%h f=%0d exp 1 0 00 0", seq_err, out_valid, out_b, frame_cnt);
    end
  endtask

  task automatic test_wrap();
    int fexp[5] = '{1, 2, 3, 0, 1};
    int eexp[5] = '{1, 2, 3, 3, 3};
    do_reset();
    for (int i = 0; i < 5; i++) begin
      tick(1, 0, 8'(i)); tick(1, 1, 8'(i + 8'h80));
      checks++;
      if (frame_cnt !== CW'(fexp[i]) || out_valid !== 1) begin
        errors++; $display("FAIL wrap_frame[%0d] got f=%0d v=%b exp %0d 1", i, frame_cnt, out_valid, fexp[i]);
      end
    end
    for (int i = 0; i < 5; i++) begin
      tick(1, 1, 8'hEE);
      checks++;
      if (seq_err !== 1) begin errors++; $display("FAIL wrap_seqerr[%0d] got %b exp 1", i, seq_err); end
`ifdef TDM_DEMUX2_ERRCNT_EN
      checks++;
      if (err_cnt !== CW'(eexp[i])) begin errors++; $display("FAIL sat_errcnt[%0d] got %0d exp %0d", i, err_cnt, eexp[i]); end
`else
      if (eexp[i] < 0) $display("unreachable");
`endif
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int n = 0; n < 600; n++) begin
      bit v, s;
      v = ($urandom_range(0, 3) != 0);
      // Bias towards well-formed A,B alternation with occasional tag errors.
      s = ($urandom_range(0, 5) == 0) ? bit'($urandom_range(0, 1)) : m_pend;
      tick(v, s, 8'($urandom));
      checks++;
      if (out_valid !== m_vld || seq_err !== m_err || out_a !== m_a || out_b !== m_b || frame_cnt !== CW'(m_fcnt)) begin
        errors++;
        $display("FAIL rand[%0d] got v=%b e=%b a=%h b=%h f=%0d exp %b %b %h %h %0d", n,
                 out_valid, seq_err, out_a, out_b, frame_cnt, m_vld, m_err, m_a, m_b, m_fcnt);
      end
      checks++;
      if ((out_valid & seq_err) !== 1'b0) begin errors++; $display("FAIL rand_excl[%0d] got both high exp not both", n); end
`ifdef TDM_DEMUX2_ERRCNT_EN
      checks++;
      if (err_cnt !== CW'(m_ecnt)) begin errors++; $display("FAIL rand_errcnt[%0d] got %0d exp %0d", n, err_cnt, m_ecnt); end
`endif
      if (n % 150 == 149) do_reset();
    end
  endtask

  initial begin
    model_clear();
    @(negedge clk);
    test_reset();
    test_basic_pair();
    test_back_to_back();
    test_bad_b();
    test_restart();
    test_reset_midframe();
    test_wrap();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
